// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants, polarity helpers and clog2 for the
// multiplexed seven-segment scanner.
`default_nettype none

package seg_scan_pkg;

    localparam int unsigned NUM_DIG = 6;
    localparam int unsigned SEC_L   = 0;
    localparam int unsigned SEC_H   = 1;
    localparam int unsigned MIN_L   = 2;
    localparam int unsigned MIN_H   = 3;
    localparam int unsigned HR_L    = 4;
    localparam int unsigned HR_H    = 5;

    // The "0" glyph as an active-low pattern (segment g dark).
    localparam logic [6:0] ZERO_PAT = 7'b1000000;

    typedef enum logic [0:0] {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    function automatic logic [6:0] seg_off(input bit active_low);
        return active_low ? 7'h7F : 7'h00;
    endfunction

    function automatic logic [5:0] dig_off(input bit active_low);
        return active_low ? 6'h3F : 6'h00;
    endfunction

    function automatic logic [6:0] zero_pat(input bit active_low);
        return active_low ? ZERO_PAT : ~ZERO_PAT;
    endfunction

    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned     r = 0;
        longint unsigned p = 1;
        while (p < v) begin
            p = p << 1;
            r++;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_tick_div.sv
// tick_div: free-running divider emitting a one-cycle pulse every DIV cycles.
`default_nettype none

module tick_div
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned  W    = (DIV > 1) ? clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    if (DIV < 1) begin : g_chk_div
        $error("tick_div: DIV must be at least 1");
    end

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexes six seven-segment patterns onto one bus with
// anti-ghost blanking, per-digit blink and hours-high leading-zero blanking.
`default_nettype none

module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned BLANK_CYC      = 500,
    parameter int unsigned BLINK_HZ       = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] secSegL,
    input  logic [6:0] secSegH,
    input  logic [6:0] minSegL,
    input  logic [6:0] minSegH,
    input  logic [6:0] hrSegL,
    input  logic [6:0] hrSegH,
    input  logic       en,
    input  logic [5:0] blink_mask,
    input  logic       lzb,
    output logic [6:0] seg,
    output logic [5:0] dig
);

    localparam int unsigned   DWELL     = CLK_HZ / SCAN_HZ;
    localparam int unsigned   BLINK_DIV = (BLINK_HZ > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
    localparam int unsigned   CW        = clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_V   = CW'(BLANK_CYC);
    localparam logic [6:0]    SEG_OFF_V = seg_off(SEG_ACTIVE_LOW);
    localparam logic [5:0]    DIG_OFF_V = dig_off(DIG_ACTIVE_LOW);
    localparam logic [6:0]    ZERO_V    = zero_pat(SEG_ACTIVE_LOW);

    if (DWELL < 2) begin : g_chk_dwell
        $error("seg_scan: CLK_HZ/SCAN_HZ must be at least 2");
    end
    if (BLANK_CYC >= DWELL) begin : g_chk_blank
        $error("seg_scan: BLANK_CYC must be less than the dwell length");
    end
    if (CLK_HZ < 2 * BLINK_HZ) begin : g_chk_blink
        $error("seg_scan: CLK_HZ must be at least 2*BLINK_HZ");
    end

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [6:0]    snap;
    logic          blink_phase;
    logic          blink_tick;
    logic          blank;
    phase_t        phase;
    logic [6:0]    live_pat;
    logic [6:0]    cur_pat;
    logic [5:0]    onehot;
    logic          suppress;
    logic [6:0]    seg_nxt;
    logic [5:0]    dig_nxt;

    tick_div #(
        .DIV (BLINK_DIV)
    ) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .tick (blink_tick)
    );

    if (BLANK_CYC == 0) begin : g_no_blank
        assign blank = 1'b0;
    end else begin : g_blank
        assign blank = (cnt < BLANK_V);
    end

    always_comb begin
        live_pat = SEG_OFF_V;
        case (idx)
            3'(SEC_L): live_pat = secSegL;
            3'(SEC_H): live_pat = secSegH;
            3'(MIN_L): live_pat = minSegL;
            3'(MIN_H): live_pat = minSegH;
            3'(HR_L):  live_pat = hrSegL;
            3'(HR_H):  live_pat = hrSegH;
            default:   live_pat = SEG_OFF_V;
        endcase
    end

    // On the first dwell cycle the snapshot register is only being loaded,
    // so the live pattern stands in for it (matters when BLANK_CYC is 0).
    always_comb begin
        phase    = blank ? PH_BLANK : PH_SHOW;
        cur_pat  = (cnt == '0) ? live_pat : snap;
        onehot   = 6'(1) << idx;
        suppress = ((|(blink_mask & onehot)) && blink_phase) ||
                   (lzb && (idx == 3'(HR_H)) && (cur_pat == ZERO_V));
        seg_nxt  = SEG_OFF_V;
        dig_nxt  = DIG_OFF_V;
        if (en && (phase == PH_SHOW)) begin
            dig_nxt = DIG_ACTIVE_LOW ? ~onehot : onehot;
            if (!suppress) begin
                seg_nxt = cur_pat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            snap        <= SEG_OFF_V;
            blink_phase <= 1'b0;
            seg         <= SEG_OFF_V;
            dig         <= DIG_OFF_V;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == 3'(HR_H)) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (cnt == '0) begin
                snap <= live_pat;
            end
            if (blink_tick) begin
                blink_phase <= ~blink_phase;
            end
            seg <= seg_nxt;
            dig <= dig_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench; a time-based reference model predicts every
// output cycle and a monitor compares the registered pins against it.
`timescale 1ns/1ps
`default_nettype none

module tb_seg_scan;

    localparam int CLK_HZ    = 1200;
    localparam int SCAN_HZ   = 100;
    localparam int BLANK_CYC = 2;
    localparam int BLINK_HZ  = 10;
    localparam int DWELL     = CLK_HZ / SCAN_HZ;
    localparam int HALF      = CLK_HZ / (2 * BLINK_HZ);

    typedef struct packed {
        logic [6:0] seg;
        logic [5:0] dig;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] pat [6];
    logic       en = 1'b1;
    logic [5:0] blink_mask = 6'h00;
    logic       lzb = 1'b0;
    logic [6:0] seg;
    logic [5:0] dig;

    exp_t       q[$];
    int         m_t = 0;
    logic [6:0] m_snap = 7'h7F;
    int         cyc_no = 0;
    int         checks = 0;
    int         failures = 0;
    bit         done = 1'b0;

    seg_scan #(
        .CLK_HZ         (CLK_HZ),
        .SCAN_HZ        (SCAN_HZ),
        .BLANK_CYC      (BLANK_CYC),
        .BLINK_HZ       (BLINK_HZ),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .secSegL    (pat[0]),
        .secSegH    (pat[1]),
        .minSegL    (pat[2]),
        .minSegH    (pat[3]),
        .hrSegL     (pat[4]),
        .hrSegH     (pat[5]),
        .en         (en),
        .blink_mask (blink_mask),
        .lzb        (lzb),
        .seg        (seg),
        .dig        (dig)
    );

    always #5 clk = ~clk;

    // Predict the pins after the coming edge. m_t counts edges since reset
    // release; digit, dwell position and blink phase all follow from it.
    task automatic model_push();
        exp_t e;
        int   cnt;
        int   idx;
        int   ph;
        e.seg = 7'h7F;
        e.dig = 6'h3F;
        if (rst) begin
            m_t    = 0;
            m_snap = 7'h7F;
        end else begin
            cnt = m_t % DWELL;
            idx = (m_t / DWELL) % 6;
            ph  = (m_t / HALF) % 2;
            if (cnt == 0) m_snap = pat[idx];
            if (en && cnt >= BLANK_CYC) begin
                e.dig = ~(6'(1) << idx);
                if (!((blink_mask[idx] && ph == 1) ||
                      (lzb && idx == 5 && m_snap == 7'b1000000)))
                    e.seg = m_snap;
            end
            m_t++;
        end
        q.push_back(e);
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_push();
            @(negedge clk);
        end
    endtask

    // Advance until the next edge will see the given position in a 72-cycle frame.
    task automatic wait_frame_pos(input int pos);
        for (int i = 0; i < 80 && (m_t % (6 * DWELL)) != pos; i++) cyc();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            cyc_no++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty cyc=%0d", cyc_no);
            end else begin
                e = q.pop_front();
                checks++;
                if (seg !== e.seg) begin
                    failures++;
                    $display("FAIL seg cyc=%0d got=%h want=%h", cyc_no, seg, e.seg);
                end
                checks++;
                if (dig !== e.dig) begin
                    failures++;
                    $display("FAIL dig cyc=%0d got=%h want=%h", cyc_no, dig, e.dig);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24;
        pat[3] = 7'h30; pat[4] = 7'h19; pat[5] = 7'h12;

        // Reset, first digit and a full rotation.
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(80);

        // Mid-dwell change of digit 0 must wait for its next dwell.
        wait_frame_pos(5);
        pat[0] = 7'h79;
        cyc(90);

        // Blink digit 2.
        blink_mask = 6'b000100;
        cyc(250);
        blink_mask = 6'b000000;

        // Leading-zero blanking of hours-high.
        pat[5] = 7'b1000000;
        lzb = 1'b1;
        cyc(80);
        lzb = 1'b0;
        cyc(80);

        // Display disable, then reset at dwell position 7 of digit 3.
        en = 1'b0;
        cyc(30);
        en = 1'b1;
        cyc(20);
        wait_frame_pos(3 * DWELL + 7);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc(40);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0)
                pat[$urandom_range(0, 5)] = ($urandom_range(0, 3) == 0) ? 7'h40 : 7'($urandom);
            if ($urandom_range(0, 49) == 0) blink_mask = 6'($urandom);
            if ($urandom_range(0, 39) == 0) lzb = ~lzb;
            if ($urandom_range(0, 59) == 0) en = ~en;
            rst = ($urandom_range(0, 399) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc(5);

        done = 1'b1;
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
